jt51_timer_ctrl: RTL and testbench

Register-side controller for the YM2151 timer pair. It decodes CPU register writes to addresses 0x10–0x14 into the value, load, run and flag-control signals consumed by `jt51_timers`. It holds every one-shot command until the next clock-enable edge so the timers sample it exactly once. It also runs the CSM (composite sine mode) sequencer, which turns each timer-A overflow into a key-on/key-off sweep over the 8 channels.

---
 rtl/jt51_timer_pkg.sv | 25 ++
 rtl/jt51_timer_ctrl_if.sv | 11 +
 rtl/jt51_csm_seq.sv | 77 +++++++
 rtl/jt51_timer_ctrl.sv | 99 +++++++++
 tb/tb_jt51_timer_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jt51_timer_pkg.sv
// Shared constants for the YM2151 timer register controller:
// register addresses, control-register bit positions and CSM state encoding.
package jt51_timer_pkg;

    localparam logic [7:0] TIMER_A_HI = 8'h10;
    localparam logic [7:0] TIMER_A_LO = 8'h11;
    localparam logic [7:0] TIMER_B    = 8'h12;
    localparam logic [7:0] TIMER_CTL  = 8'h14;

    // Bit positions inside the 0x14 control register
    localparam int CTL_LOAD_A     = 0;
    localparam int CTL_LOAD_B     = 1;
    localparam int CTL_IRQ_A      = 2;
    localparam int CTL_IRQ_B      = 3;
    localparam int CTL_CLR_FLAG_A = 4;
    localparam int CTL_CLR_FLAG_B = 5;
    localparam int CTL_CSM        = 7;

    typedef enum logic [1:0] {
        CSM_IDLE = 2'd0,
        CSM_KON  = 2'd1,
        CSM_KOFF = 2'd2
    } csm_state_t;

endpackage

// File: rtl/jt51_timer_ctrl_if.sv
// CPU register-write bus into the timer controller.
interface jt51_timer_ctrl_if;

    logic       wr;
    logic [7:0] addr;
    logic [7:0] din;

    modport master (output wr, addr, din);
    modport slave  (input  wr, addr, din);

endinterface

// File: rtl/jt51_csm_seq.sv
// CSM sequencer: each accepted timer-A overflow produces a key-on sweep
// followed by a key-off sweep across all channels, one channel per cen.
module jt51_csm_seq
    import jt51_timer_pkg::*;
#(
    parameter  int NCH = 8,
    localparam int CHW = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cen,
    input  logic           overflow_A,
    input  logic           csm,
    output logic           csm_kon,
    output logic           csm_koff,
    output logic [CHW-1:0] csm_ch,
    output logic           csm_busy
);

    localparam logic [CHW-1:0] LAST_CH = CHW'(NCH - 1);

    csm_state_t     state;
    logic [CHW-1:0] idx;

    assign csm_ch = idx;

    // Overflows are only looked at from IDLE, so they never restart or queue a sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CSM_IDLE;
            idx      <= '0;
            csm_kon  <= 1'b0;
            csm_koff <= 1'b0;
            csm_busy <= 1'b0;
        end else if (cen) begin
            case (state)
                CSM_IDLE: begin
                    if (overflow_A && csm) begin
                        state    <= CSM_KON;
                        idx      <= '0;
                        csm_kon  <= 1'b1;
                        csm_koff <= 1'b0;
                        csm_busy <= 1'b1;
                    end
                end
                CSM_KON: begin
                    if (idx == LAST_CH) begin
                        state    <= CSM_KOFF;
                        idx      <= '0;
                        csm_kon  <= 1'b0;
                        csm_koff <= 1'b1;
                    end else begin
                        idx <= idx + CHW'(1);
                    end
                end
                CSM_KOFF: begin
                    if (idx == LAST_CH) begin
                        state    <= CSM_IDLE;
                        idx      <= '0;
                        csm_koff <= 1'b0;
                        csm_busy <= 1'b0;
                    end else begin
                        idx <= idx + CHW'(1);
                    end
                end
                default: begin
                    state    <= CSM_IDLE;
                    idx      <= '0;
                    csm_kon  <= 1'b0;
                    csm_koff <= 1'b0;
                    csm_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/jt51_timer_ctrl.sv
// Register-side controller for the YM2151 timer pair: decodes 0x10-0x14 writes,
// holds one-shot commands until the next cen edge and hosts the CSM sequencer.
module jt51_timer_ctrl
    import jt51_timer_pkg::*;
#(
    parameter  int NCH = 8,
    localparam int CHW = $clog2(NCH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cen,
    jt51_timer_ctrl_if.slave       bus,
    input  logic                   overflow_A,
    output logic [9:0]             value_A,
    output logic [7:0]             value_B,
    output logic                   load_A,
    output logic                   load_B,
    output logic                   clr_run_A,
    output logic                   clr_run_B,
    output logic                   clr_flag_A,
    output logic                   clr_flag_B,
    output logic                   enable_irq_A,
    output logic                   enable_irq_B,
    output logic                   csm,
    output logic                   csm_kon,
    output logic                   csm_koff,
    output logic [CHW-1:0]         csm_ch,
    output logic                   csm_busy
);

    logic wr_ctl;

    assign wr_ctl = bus.wr && (bus.addr == TIMER_CTL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_A      <= '0;
            value_B      <= '0;
            enable_irq_A <= 1'b0;
            enable_irq_B <= 1'b0;
            csm          <= 1'b0;
        end else if (bus.wr) begin
            case (bus.addr)
                TIMER_A_HI: value_A[9:2] <= bus.din;
                TIMER_A_LO: value_A[1:0] <= bus.din[1:0];
                TIMER_B:    value_B      <= bus.din;
                TIMER_CTL: begin
                    csm          <= bus.din[CTL_CSM];
                    enable_irq_B <= bus.din[CTL_IRQ_B];
                    enable_irq_A <= bus.din[CTL_IRQ_A];
                end
                default: ;
            endcase
        end
    end

    // A cen edge consumes the held commands; a write on the same clk re-arms
    // afterwards so its commands survive to the following cen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_A     <= 1'b0;
            load_B     <= 1'b0;
            clr_run_A  <= 1'b0;
            clr_run_B  <= 1'b0;
            clr_flag_A <= 1'b0;
            clr_flag_B <= 1'b0;
        end else begin
            if (cen) begin
                load_A     <= 1'b0;
                load_B     <= 1'b0;
                clr_run_A  <= 1'b0;
                clr_run_B  <= 1'b0;
                clr_flag_A <= 1'b0;
                clr_flag_B <= 1'b0;
            end
            if (wr_ctl) begin
                load_A    <=  bus.din[CTL_LOAD_A];
                clr_run_A <= ~bus.din[CTL_LOAD_A];
                load_B    <=  bus.din[CTL_LOAD_B];
                clr_run_B <= ~bus.din[CTL_LOAD_B];
                if (bus.din[CTL_CLR_FLAG_A]) clr_flag_A <= 1'b1;
                if (bus.din[CTL_CLR_FLAG_B]) clr_flag_B <= 1'b1;
            end
        end
    end

    jt51_csm_seq #(.NCH(NCH)) u_csm_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .cen        (cen),
        .overflow_A (overflow_A),
        .csm        (csm),
        .csm_kon    (csm_kon),
        .csm_koff   (csm_koff),
        .csm_ch     (csm_ch),
        .csm_busy   (csm_busy)
    );

endmodule

// File: tb/tb_jt51_timer_ctrl.sv
// Scoreboard bench for jt51_timer_ctrl: a behavioural model queues the expected
// outputs for every clk and a negedge monitor pops and compares them.
module tb_jt51_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b0;
    logic       overflow_A = 1'b0;
    logic [9:0] value_A;
    logic [7:0] value_B;
    logic       load_A, load_B, clr_run_A, clr_run_B, clr_flag_A, clr_flag_B;
    logic       enable_irq_A, enable_irq_B, csm, csm_kon, csm_koff, csm_busy;
    logic [2:0] csm_ch;

    jt51_timer_ctrl_if bus();

    jt51_timer_ctrl #(.NCH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cen          (cen),
        .bus          (bus),
        .overflow_A   (overflow_A),
        .value_A      (value_A),
        .value_B      (value_B),
        .load_A       (load_A),
        .load_B       (load_B),
        .clr_run_A    (clr_run_A),
        .clr_run_B    (clr_run_B),
        .clr_flag_A   (clr_flag_A),
        .clr_flag_B   (clr_flag_B),
        .enable_irq_A (enable_irq_A),
        .enable_irq_B (enable_irq_B),
        .csm          (csm),
        .csm_kon      (csm_kon),
        .csm_koff     (csm_koff),
        .csm_ch       (csm_ch),
        .csm_busy     (csm_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] va;
        logic [7:0] vb;
        logic [2:0] lvl;
        logic [5:0] shot;
        logic       kon;
        logic       koff;
        logic [2:0] ch;
        logic       busy;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state: what the DUT should show on the next clk
    logic [9:0] m_va;
    logic [7:0] m_vb;
    logic       m_csm, m_irq_a, m_irq_b;
    logic [5:0] m_shot;
    int         m_step;
    int         cyc = 0;

    task automatic modelReset();
        m_va = '0; m_vb = '0;
        m_csm = 1'b0; m_irq_a = 1'b0; m_irq_b = 1'b0;
        m_shot = '0;
        m_step = -1;
    endtask

    function automatic exp_t modelOut();
        exp_t e;
        e.va   = m_va;
        e.vb   = m_vb;
        e.lvl  = {m_csm, m_irq_b, m_irq_a};
        e.shot = m_shot;
        e.kon  = (m_step >= 0) && (m_step < 8);
        e.koff = (m_step >= 8);
        e.ch   = (m_step >= 0) ? 3'(m_step % 8) : 3'd0;
        e.busy = (m_step >= 0);
        return e;
    endfunction

    task automatic check1(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        check1("value_A", 64'(value_A), 64'(e.va));
        check1("value_B", 64'(value_B), 64'(e.vb));
        check1("levels csm/irqB/irqA", 64'({csm, enable_irq_B, enable_irq_A}), 64'(e.lvl));
        check1("one-shots cfB/cfA/crB/crA/ldB/ldA",
               64'({clr_flag_B, clr_flag_A, clr_run_B, clr_run_A, load_B, load_A}), 64'(e.shot));
        check1("csm kon/koff/ch/busy", 64'({csm_kon, csm_koff, csm_ch, csm_busy}),
               64'({e.kon, e.koff, e.ch, e.busy}));
    endtask

    task automatic checkAllZero(input string name);
        check1({name, " values"}, 64'({value_A, value_B}), 64'd0);
        check1({name, " controls"},
               64'({load_A, load_B, clr_run_A, clr_run_B, clr_flag_A, clr_flag_B,
                    enable_irq_A, enable_irq_B, csm, csm_kon, csm_koff, csm_ch, csm_busy}), 64'd0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && sbq.size() > 0) begin
            e = sbq.pop_front();
            checkOutput(e);
        end
    end

    // One clk of stimulus: queue what the DUT shows this clk, then advance the model
    task automatic applyStimulus(input logic w, input logic [7:0] a, input logic [7:0] d,
                                 input logic c, input logic o);
        @(posedge clk);
        #1;
        bus.wr = w; bus.addr = a; bus.din = d; cen = c; overflow_A = o;
        sbq.push_back(modelOut());
        if (c) begin
            if (m_step >= 0) begin
                m_step++;
                if (m_step == 16) m_step = -1;
            end else if (o && m_csm) begin
                m_step = 0;
            end
            m_shot = '0;
        end
        if (w) begin
            case (a)
                8'h10: m_va[9:2] = d;
                8'h11: m_va[1:0] = d[1:0];
                8'h12: m_vb = d;
                8'h14: begin
                    m_csm = d[7]; m_irq_b = d[3]; m_irq_a = d[2];
                    m_shot[0] = d[0];  m_shot[1] = d[1];
                    m_shot[2] = ~d[0]; m_shot[3] = ~d[1];
                    m_shot[4] = m_shot[4] | d[4];
                    m_shot[5] = m_shot[5] | d[5];
                end
                default: ;
            endcase
        end
        cyc++;
    endtask

    task automatic tick(input logic w, input logic [7:0] a, input logic [7:0] d, input logic o);
        applyStimulus(w, a, d, (cyc % 4) == 3, o);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic writeReg(input logic [7:0] a, input logic [7:0] d);
        tick(1'b1, a, d, 1'b0);
    endtask

    task automatic alignTo(input int ph);
        while ((cyc % 4) != ph) idle(1);
    endtask

    task automatic startSweep();
        alignTo(3);
        tick(1'b0, 8'h00, 8'h00, 1'b1);
    endtask

    task automatic resetPulse();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("async reset");
        bus.wr = 1'b0; cen = 1'b0; overflow_A = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        int ncen;
        int guard;
        logic isc;
        logic [7:0] a;
        bus.wr = 1'b0; bus.addr = 8'h00; bus.din = 8'h00;
        modelReset();
        #12;
        checkAllZero("reset state");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Values and load
        idle(4);
        writeReg(8'h10, 8'hAB);
        writeReg(8'h11, 8'h03);
        writeReg(8'h12, 8'h5C);
        writeReg(8'h14, 8'h03);
        idle(8);
        check1("value_A after writes", 64'(value_A), 64'h2AF);

        // Stop and flag reset
        writeReg(8'h14, 8'h30);
        idle(8);

        // Last write wins between cen edges
        alignTo(0);
        writeReg(8'h14, 8'h01);
        writeReg(8'h14, 8'h10);
        idle(8);

        // Write coincident with a cen clk
        alignTo(3);
        writeReg(8'h14, 8'h02);
        idle(8);

        // CSM sweep with a second overflow at step 5
        writeReg(8'h14, 8'h80);
        idle(2);
        startSweep();
        ncen = 0;
        repeat (80) begin
            isc = (cyc % 4) == 3;
            tick(1'b0, 8'h00, 8'h00, isc && (ncen == 5));
            if (isc) ncen++;
        end

        // csm=0 blocks new sweeps
        writeReg(8'h14, 8'h00);
        startSweep();
        idle(70);

        // csm cleared mid-sweep does not abort
        writeReg(8'h14, 8'h80);
        startSweep();
        idle(10);
        writeReg(8'h14, 8'h00);
        idle(70);

        // Reset during KON ch3
        writeReg(8'h14, 8'h80);
        startSweep();
        guard = 0;
        while (m_step != 3 && guard < 40) begin
            idle(1);
            guard++;
        end
        check1("reach KON ch3 within budget", 64'(guard < 40), 64'd1);
        idle(1);
        resetPulse();
        idle(70);

        // Randomized traffic
        for (int i = 0; i < 700; i++) begin
            case ($urandom_range(0, 7))
                0: a = 8'h10;
                1: a = 8'h11;
                2: a = 8'h12;
                3, 4: a = 8'h14;
                5: a = 8'h13;
                6: a = 8'h15;
                default: a = 8'($urandom_range(0, 255));
            endcase
            applyStimulus($urandom_range(0, 2) == 0, a, 8'($urandom_range(0, 255)),
                          $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
            if (i == 350) resetPulse();
        end
        idle(4);

        @(negedge clk);
        #1;
        check1("scoreboard drained", 64'(sbq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
